// File: rtl/microseq_pkg.sv
// microseq_pkg: shared types for the microsequencer.
// Optional wait timeout is enabled with MICROSEQ_TIMEOUT_EN.
package microseq_pkg;

  localparam int ADDR_W = 9;

  typedef enum logic [2:0] {
    NS_INC  = 3'b000,
    NS_JMP  = 3'b001,
    NS_DEC  = 3'b010,
    NS_CBR  = 3'b011,
    NS_CALL = 3'b100,
    NS_RET  = 3'b101,
    NS_CDEC = 3'b110,
    NS_WAIT = 3'b111
  } ns_ctrl_e;

  typedef enum logic [1:0] {
    COND_MOC  = 2'b00,
    COND_ICC  = 2'b01,
    COND_IBIT = 2'b10,
    COND_TRAP = 2'b11
  } cond_sel_e;

endpackage

// File: rtl/micro_return_stack.sv
// micro_return_stack: LIFO of microsubroutine return addresses.
// Push on full and pop on empty are dropped and flagged.
module micro_return_stack #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              ovf_o,
  output logic              unf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic              full;
  logic              do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign wr_idx  = cnt_q[AW-1:0];
  assign rd_idx  = wr_idx - AW'(1);
  assign top_o   = mem_q[rd_idx];
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;
  assign ovf_o   = push_i && full;
  assign unf_o   = pop_i && empty_o;

  // Entry count follows committed pushes and pops
  always_comb begin
    cnt_d = cnt_q;
    if (do_push)
      cnt_d = cnt_q + CW'(1);
    else if (do_pop)
      cnt_d = cnt_q - CW'(1);
  end

  // Storage and pointer; reset discards every entry
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push)
        mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/microsequencer.sv
// microsequencer: next-microstate generator with return stack.
// Define MICROSEQ_TIMEOUT_EN to trap on a WAIT that never completes.
module microsequencer
  import microseq_pkg::*;
#(
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_STATE = '0,
  parameter logic [ADDR_W-1:0] TRAP_STATE  = ADDR_W'(500),
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [2:0]        NS_Ctrl,
  input  logic              INV_Ctrl,
  input  logic [1:0]        COND_Sel,
  input  logic [ADDR_W-1:0] CR_Addr,
  input  logic [ADDR_W-1:0] Encoder_Addr,
  input  logic              MOC,
  input  logic              Cond,
  input  logic              IR_Bit,
  input  logic              Trap_Pending,
  output logic [ADDR_W-1:0] Next_State,
  output logic [ADDR_W-1:0] State,
  output logic              Stack_Err,
  output logic              Timeout
);

  if (STACK_DEPTH < 2 ||
      (STACK_DEPTH & (STACK_DEPTH - 1)) != 0 ||
      TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("microsequencer: bad parameters");
  end

  ns_ctrl_e          op;
  logic [ADDR_W-1:0] state_q, ns_d, inc;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_empty, stk_ovf, stk_unf;
  logic              sel, c;
  logic              err_q;
  logic              tmo_hit;

  assign op  = ns_ctrl_e'(NS_Ctrl);
  assign inc = state_q + ADDR_W'(1);
  assign c   = sel ^ INV_Ctrl;

  // Condition source multiplexer
  always_comb begin
    sel = 1'b0;
    unique case (cond_sel_e'(COND_Sel))
      COND_MOC:  sel = MOC;
      COND_ICC:  sel = Cond;
      COND_IBIT: sel = IR_Bit;
      COND_TRAP: sel = Trap_Pending;
    endcase
  end

  // Next microstate; timeout and reset override the opcode
  always_comb begin
    ns_d = inc;
    unique case (op)
      NS_INC:  ns_d = inc;
      NS_JMP:  ns_d = CR_Addr;
      NS_DEC:  ns_d = Encoder_Addr;
      NS_CBR:  ns_d = c ? CR_Addr : inc;
      NS_CALL: ns_d = CR_Addr;
      NS_RET:  ns_d = stk_empty ? RESET_STATE : stk_top;
      NS_CDEC: ns_d = c ? Encoder_Addr : CR_Addr;
      NS_WAIT: ns_d = c ? inc : state_q;
    endcase
    if (tmo_hit)
      ns_d = TRAP_STATE;
    if (Reset)
      ns_d = RESET_STATE;
  end

  assign Next_State = ns_d;
  assign State      = state_q;
  assign Stack_Err  = err_q;

  micro_return_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .push_i  (op == NS_CALL),
    .pop_i   (op == NS_RET),
    .data_i  (inc),
    .top_o   (stk_top),
    .empty_o (stk_empty),
    .ovf_o   (stk_ovf),
    .unf_o   (stk_unf)
  );

  // Current microstate and sticky stack error
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= RESET_STATE;
      err_q   <= 1'b0;
    end else begin
      state_q <= ns_d;
      err_q   <= err_q | stk_ovf | stk_unf;
    end
  end

`ifdef MICROSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          tmo_q;
  logic          waiting;

  assign waiting = (op == NS_WAIT) && !c;
  assign tmo_hit = waiting &&
                   (wcnt_q == TW'(TIMEOUT_CYC - 1));
  assign wcnt_d  = (waiting && !tmo_hit) ?
                   wcnt_q + TW'(1) : '0;
  assign Timeout = tmo_q;

  // Stalled-wait counter and sticky timeout flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      tmo_q  <= tmo_q | tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer: directed and random checks of microsequencer
// against a queue-based model of the sequencing rules.
module tb_microsequencer;

  logic       Clock;
  logic       Reset;
  logic [2:0] NS_Ctrl;
  logic       INV_Ctrl;
  logic [1:0] COND_Sel;
  logic [8:0] CR_Addr;
  logic [8:0] Encoder_Addr;
  logic       MOC, Cond, IR_Bit, Trap_Pending;
  logic [8:0] Next_State, State;
  logic       Stack_Err, Timeout;

  int n_tests = 0;
  int n_fail  = 0;

  int m_state = 0;
  int m_stack[$];
  bit m_err = 0;
  bit m_tmo = 0;
`ifdef MICROSEQ_TIMEOUT_EN
  int m_wcnt = 0;
  localparam bit TMO_EN = 1;
`else
  localparam bit TMO_EN = 0;
`endif

  microsequencer dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .NS_Ctrl      (NS_Ctrl),
    .INV_Ctrl     (INV_Ctrl),
    .COND_Sel     (COND_Sel),
    .CR_Addr      (CR_Addr),
    .Encoder_Addr (Encoder_Addr),
    .MOC          (MOC),
    .Cond         (Cond),
    .IR_Bit       (IR_Bit),
    .Trap_Pending (Trap_Pending),
    .Next_State   (Next_State),
    .State        (State),
    .Stack_Err    (Stack_Err),
    .Timeout      (Timeout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic bit m_cond();
    bit s;
    case (COND_Sel)
      2'd0: s = MOC;
      2'd1: s = Cond;
      2'd2: s = IR_Bit;
      default: s = Trap_Pending;
    endcase
    return s ^ INV_Ctrl;
  endfunction

  function automatic int m_next();
    bit c = m_cond();
    int inc = (m_state + 1) % 512;
    int n;
    if (Reset) return 0;
    case (NS_Ctrl)
      3'd0: n = inc;
      3'd1: n = CR_Addr;
      3'd2: n = Encoder_Addr;
      3'd3: n = c ? int'(CR_Addr) : inc;
      3'd4: n = CR_Addr;
      3'd5: n = (m_stack.size() == 0) ? 0 : m_stack[$];
      3'd6: n = c ? int'(Encoder_Addr) : int'(CR_Addr);
      default: n = c ? inc : m_state;
    endcase
`ifdef MICROSEQ_TIMEOUT_EN
    if (NS_Ctrl == 3'd7 && !c && m_wcnt == 15) n = 500;
`endif
    return n;
  endfunction

  task automatic tick();
    int n;
    bit c;
    n = m_next();
    c = m_cond();
    if (Reset) begin
      m_stack.delete();
      m_err = 0;
      m_tmo = 0;
`ifdef MICROSEQ_TIMEOUT_EN
      m_wcnt = 0;
`endif
    end else begin
      if (NS_Ctrl == 3'd4) begin
        if (m_stack.size() < 4)
          m_stack.push_back((m_state + 1) % 512);
        else
          m_err = 1;
      end
      if (NS_Ctrl == 3'd5) begin
        if (m_stack.size() == 0) m_err = 1;
        else void'(m_stack.pop_back());
      end
`ifdef MICROSEQ_TIMEOUT_EN
      if (NS_Ctrl == 3'd7 && !c) begin
        if (m_wcnt == 15) begin
          m_tmo = 1;
          m_wcnt = 0;
        end else m_wcnt++;
      end else m_wcnt = 0;
`endif
    end
    m_state = n;
    @(posedge Clock);
    #1;
  endtask

  task automatic goto(input int a);
    NS_Ctrl = 3'd1;
    CR_Addr = 9'(a);
    tick();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    NS_Ctrl = 3'd1;
    CR_Addr = 9'd77;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (State !== 9'd0 || Next_State !== 9'd0) begin
        n_fail++;
        $display("FAIL reset_hold%0d: State=%0d Next=%0d want 0/0",
                 i, State, Next_State);
      end
    end
    n_tests++;
    if (Stack_Err !== 1'b0 || Timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: err=%b tmo=%b want 0/0",
               Stack_Err, Timeout);
    end
    Reset = 1'b0;
    #1;
    n_tests++;
    if (Next_State !== 9'd77) begin
      n_fail++;
      $display("FAIL release_next: got %0d want 77", Next_State);
    end
    tick();
    n_tests++;
    if (State !== 9'd77) begin
      n_fail++;
      $display("FAIL release_state: got %0d want 77", State);
    end
  endtask

  task automatic test_cbr();
    goto(10);
    NS_Ctrl = 3'd3; COND_Sel = 2'd1; Cond = 1'b1;
    INV_Ctrl = 1'b0; CR_Addr = 9'd40;
    #1;
    n_tests++;
    if (Next_State !== 9'd40) begin
      n_fail++;
      $display("FAIL cbr_next: got %0d want 40", Next_State);
    end
    tick();
    n_tests++;
    if (State !== 9'd40) begin
      n_fail++;
      $display("FAIL cbr_taken: got %0d want 40", State);
    end
    goto(10);
    NS_Ctrl = 3'd3; INV_Ctrl = 1'b1; CR_Addr = 9'd40;
    tick();
    n_tests++;
    if (State !== 9'd11) begin
      n_fail++;
      $display("FAIL cbr_inverted: got %0d want 11", State);
    end
    INV_Ctrl = 1'b0;
  endtask

  task automatic test_wrap();
    goto(511);
    NS_Ctrl = 3'd0;
    tick();
    n_tests++;
    if (State !== 9'd0) begin
      n_fail++;
      $display("FAIL inc_wrap: got %0d want 0", State);
    end
  endtask

  task automatic test_call_ret();
    int want[4] = '{101, 21, 0, 0};
    int rets[4] = '{303, 302, 301, 22};
    do_reset();
    goto(20);
    NS_Ctrl = 3'd4; CR_Addr = 9'd100; tick();
    CR_Addr = 9'd200; tick();
    n_tests++;
    if (State !== 9'd200) begin
      n_fail++;
      $display("FAIL call_nested: got %0d want 200", State);
    end
    NS_Ctrl = 3'd5;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (State !== 9'(want[i])) begin
        n_fail++;
        $display("FAIL ret%0d: got %0d want %0d", i, State, want[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      NS_Ctrl = 3'd4;
      CR_Addr = 9'(300 + i);
      tick();
      n_tests++;
      if (State !== 9'(300 + i) || Stack_Err !== (i == 4)) begin
        n_fail++;
        $display("FAIL call%0d: State=%0d err=%b want %0d/%0b",
                 i, State, Stack_Err, 300 + i, i == 4);
      end
    end
    NS_Ctrl = 3'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (State !== 9'(rets[i])) begin
        n_fail++;
        $display("FAIL deep_ret%0d: got %0d want %0d",
                 i, State, rets[i]);
      end
    end
    do_reset();
    goto(30);
    NS_Ctrl = 3'd5;
    tick();
    n_tests++;
    if (State !== 9'd0 || Stack_Err !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: State=%0d err=%b want 0/1",
               State, Stack_Err);
    end
    do_reset();
    n_tests++;
    if (Stack_Err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b want 0", Stack_Err);
    end
  endtask

  task automatic test_wait();
    goto(5);
    NS_Ctrl = 3'd7; COND_Sel = 2'd0; INV_Ctrl = 1'b0; MOC = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (State !== 9'd5) begin
        n_fail++;
        $display("FAIL wait_hold%0d: got %0d want 5", i, State);
      end
    end
    MOC = 1'b1;
    tick();
    n_tests++;
    if (State !== 9'd6) begin
      n_fail++;
      $display("FAIL wait_done: got %0d want 6", State);
    end
  endtask

  task automatic test_reset_mid();
    goto(50);
    NS_Ctrl = 3'd4; CR_Addr = 9'd60; tick();
    NS_Ctrl = 3'd7; COND_Sel = 2'd0; MOC = 1'b0; tick();
    Reset = 1'b1; tick();
    n_tests++;
    if (State !== 9'd0 || Stack_Err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: State=%0d err=%b want 0/0",
               State, Stack_Err);
    end
    Reset = 1'b0;
    NS_Ctrl = 3'd5; tick();
    n_tests++;
    if (State !== 9'd0 || Stack_Err !== 1'b1) begin
      n_fail++;
      $display("FAIL stack_discard: State=%0d err=%b want 0/1",
               State, Stack_Err);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    int fin = TMO_EN ? 500 : 5;
    goto(5);
    NS_Ctrl = 3'd7; COND_Sel = 2'd0; INV_Ctrl = 1'b0; MOC = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    n_tests++;
    if (State !== 9'd5 || Timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_pre: State=%0d tmo=%b want 5/0",
               State, Timeout);
    end
    tick();
    n_tests++;
    if (State !== 9'(fin) || Timeout !== TMO_EN) begin
      n_fail++;
      $display("FAIL tmo_edge: State=%0d tmo=%b want %0d/%0b",
               State, Timeout, fin, TMO_EN);
    end
    NS_Ctrl = 3'd0;
    tick();
    n_tests++;
    if (Timeout !== TMO_EN) begin
      n_fail++;
      $display("FAIL tmo_sticky: got %b want %0b", Timeout, TMO_EN);
    end
    do_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Reset        = ($urandom_range(39) == 0);
      NS_Ctrl      = 3'($urandom);
      INV_Ctrl     = 1'($urandom);
      COND_Sel     = 2'($urandom);
      CR_Addr      = 9'($urandom);
      Encoder_Addr = 9'($urandom);
      MOC          = 1'($urandom);
      Cond         = 1'($urandom);
      IR_Bit       = 1'($urandom);
      Trap_Pending = 1'($urandom);
      #1;
      n_tests++;
      if (Next_State !== 9'(m_next())) begin
        n_fail++;
        $display("FAIL rnd_next%0d: got %0d want %0d",
                 i, Next_State, m_next());
      end
      tick();
      n_tests++;
      if (State !== 9'(m_state) || Stack_Err !== m_err ||
          Timeout !== m_tmo) begin
        n_fail++;
        $display("FAIL rnd_state%0d: got %0d/%b/%b want %0d/%b/%b",
                 i, State, Stack_Err, Timeout,
                 m_state, m_err, m_tmo);
      end
    end
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; NS_Ctrl = 3'd0; INV_Ctrl = 1'b0; COND_Sel = 2'd0;
    CR_Addr = '0; Encoder_Addr = '0;
    MOC = 1'b0; Cond = 1'b0; IR_Bit = 1'b0; Trap_Pending = 1'b0;
    test_reset();
    test_cbr();
    test_wrap();
    test_call_ret();
    test_wait();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
